// File: rtl/rom_backdoor_axil_bridge.sv
// AXI4-Lite slave bridging host accesses onto the single-cycle ROM backdoor BRAM port.
// Optional write lock input is compiled in with `define ROM_BACKDOOR_WR_LOCK_EN.
module rom_backdoor_axil_bridge #(
  parameter int RD_LATENCY = 1,
  parameter int ROM_BYTES  = 131072
) (
  input  logic        rom_backdoor_clk,
  input  logic        S_AXI_ROM_ARESETN,
  input  logic        S_AXI_ROM_AWVALID,
  output logic        S_AXI_ROM_AWREADY,
  input  logic [31:0] S_AXI_ROM_AWADDR,
  input  logic        S_AXI_ROM_WVALID,
  output logic        S_AXI_ROM_WREADY,
  input  logic [31:0] S_AXI_ROM_WDATA,
  input  logic [3:0]  S_AXI_ROM_WSTRB,
  output logic        S_AXI_ROM_BVALID,
  input  logic        S_AXI_ROM_BREADY,
  output logic [1:0]  S_AXI_ROM_BRESP,
  input  logic        S_AXI_ROM_ARVALID,
  output logic        S_AXI_ROM_ARREADY,
  input  logic [31:0] S_AXI_ROM_ARADDR,
  output logic        S_AXI_ROM_RVALID,
  input  logic        S_AXI_ROM_RREADY,
  output logic [31:0] S_AXI_ROM_RDATA,
  output logic [1:0]  S_AXI_ROM_RRESP,
  output logic        rom_backdoor_en,
  output logic [3:0]  rom_backdoor_we,
  output logic [16:0] rom_backdoor_addr,
  output logic [31:0] rom_backdoor_din,
  input  logic [31:0] rom_backdoor_dout,
  output logic        rom_backdoor_rst
`ifdef ROM_BACKDOOR_WR_LOCK_EN
  ,
  input  logic        rom_wr_lock
`endif
);

  // state      | meaning
  // IDLE       | capture AW/W independently, or AR when no write is pending
  // WR_ACC     | one-cycle write strobe to the ROM port
  // WR_RESP    | BVALID held until BREADY
  // RD_ACC     | one-cycle read strobe to the ROM port
  // RD_WAIT    | down-count remaining read latency, capture dout at terminal count
  // RD_RESP    | RVALID held until RREADY
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_ACC  = 3'd1;
  localparam logic [2:0] ST_WR_RESP = 3'd2;
  localparam logic [2:0] ST_RD_ACC  = 3'd3;
  localparam logic [2:0] ST_RD_WAIT = 3'd4;
  localparam logic [2:0] ST_RD_RESP = 3'd5;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [31:0] ROM_LIMIT   = 32'(ROM_BYTES);
  localparam logic [0:0]  CNT_INIT    = 1'(RD_LATENCY - 1);

  logic [2:0]  state;
  logic        aw_held;
  logic        w_held;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [1:0]  bresp_q;
  logic [1:0]  rresp_q;
  logic [31:0] rdata_q;
  logic        bvalid_q;
  logic        rvalid_q;
  logic [0:0]  rd_cnt;

  logic in_idle;
  logic aw_hs;
  logic w_hs;
  logic ar_hs;
  logic addr_oor;
  logic wr_lock;
  logic wr_ok;
  logic wr_strobe;
  logic rd_strobe;

`ifdef ROM_BACKDOOR_WR_LOCK_EN
  assign wr_lock = rom_wr_lock;
`else
  assign wr_lock = 1'b0;
`endif

  assign in_idle  = (state == ST_IDLE);
  assign addr_oor = (addr_q >= ROM_LIMIT);
  assign wr_ok    = !addr_oor && !wr_lock;

  // Readies are gated by reset so every output reads 0 while reset is held.
  assign S_AXI_ROM_AWREADY = S_AXI_ROM_ARESETN && in_idle && !aw_held;
  assign S_AXI_ROM_WREADY  = S_AXI_ROM_ARESETN && in_idle && !w_held;
  assign S_AXI_ROM_ARREADY = S_AXI_ROM_ARESETN && in_idle && !aw_held && !w_held &&
                             !S_AXI_ROM_AWVALID && !S_AXI_ROM_WVALID;

  assign aw_hs = S_AXI_ROM_AWVALID && S_AXI_ROM_AWREADY;
  assign w_hs  = S_AXI_ROM_WVALID && S_AXI_ROM_WREADY;
  assign ar_hs = S_AXI_ROM_ARVALID && S_AXI_ROM_ARREADY;

  assign wr_strobe = (state == ST_WR_ACC) && wr_ok;
  assign rd_strobe = (state == ST_RD_ACC) && !addr_oor;

  assign rom_backdoor_en   = wr_strobe || rd_strobe;
  assign rom_backdoor_we   = wr_strobe ? wstrb_q : 4'h0;
  assign rom_backdoor_addr = rom_backdoor_en ? {addr_q[16:2], 2'b00} : 17'h0;
  assign rom_backdoor_din  = wr_strobe ? wdata_q : 32'h0;
  assign rom_backdoor_rst  = ~S_AXI_ROM_ARESETN;

  assign S_AXI_ROM_BVALID = bvalid_q;
  assign S_AXI_ROM_BRESP  = bresp_q;
  assign S_AXI_ROM_RVALID = rvalid_q;
  assign S_AXI_ROM_RDATA  = rdata_q;
  assign S_AXI_ROM_RRESP  = rresp_q;

  always_ff @(posedge rom_backdoor_clk or negedge S_AXI_ROM_ARESETN) begin
    if (!S_AXI_ROM_ARESETN) begin
      state    <= ST_IDLE;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      wstrb_q  <= 4'h0;
      bresp_q  <= RESP_OKAY;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= 32'h0;
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      rd_cnt   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (aw_hs) begin
            addr_q  <= S_AXI_ROM_AWADDR;
            aw_held <= 1'b1;
          end
          if (w_hs) begin
            wdata_q <= S_AXI_ROM_WDATA;
            wstrb_q <= S_AXI_ROM_WSTRB;
            w_held  <= 1'b1;
          end
          // AR can only handshake when no write is pending, so addr_q is never contended.
          if ((aw_held || aw_hs) && (w_held || w_hs)) begin
            state <= ST_WR_ACC;
          end else if (ar_hs) begin
            addr_q <= S_AXI_ROM_ARADDR;
            state  <= ST_RD_ACC;
          end
        end
        ST_WR_ACC: begin
          bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
          bvalid_q <= 1'b1;
          state    <= ST_WR_RESP;
        end
        ST_WR_RESP: begin
          if (S_AXI_ROM_BREADY) begin
            bvalid_q <= 1'b0;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        ST_RD_ACC: begin
          rresp_q <= addr_oor ? RESP_SLVERR : RESP_OKAY;
          rd_cnt  <= CNT_INIT;
          state   <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (rd_cnt == 1'b0) begin
            rdata_q  <= addr_oor ? 32'h0 : rom_backdoor_dout;
            rvalid_q <= 1'b1;
            state    <= ST_RD_RESP;
          end else begin
            rd_cnt <= rd_cnt - 1'b1;
          end
        end
        ST_RD_RESP: begin
          if (S_AXI_ROM_RREADY) begin
            rvalid_q <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_backdoor_axil_bridge.sv
// Directed bench: two bridges (read latency 1 and 2) share stimulus, each with its own BRAM model.
module tb_rom_backdoor_axil_bridge;

  logic        clk;
  logic        rst_n;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
`ifdef ROM_BACKDOOR_WR_LOCK_EN
  logic        wr_lock;
`endif

  logic        awready_a, wready_a, bvalid_a, arready_a, rvalid_a, en_a, rst_a;
  logic [1:0]  bresp_a, rresp_a;
  logic [31:0] rdata_a, din_a, dout_a;
  logic [3:0]  we_a;
  logic [16:0] addr_a;

  logic        awready_b, wready_b, bvalid_b, arready_b, rvalid_b, en_b, rst_b;
  logic [1:0]  bresp_b, rresp_b;
  logic [31:0] rdata_b, din_b, dout_b, pipe_b;
  logic [3:0]  we_b;
  logic [16:0] addr_b;

  logic [31:0] mem_a [0:32767];
  logic [31:0] mem_b [0:32767];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int en_cnt_a = 0, en_cnt_b = 0, rv_cnt_a = 0, rv_cnt_b = 0;
  logic [16:0] last_addr_a = '0;
  logic [3:0]  last_we_a = '0;

  rom_backdoor_axil_bridge #(.RD_LATENCY(1), .ROM_BYTES(131072)) u_dut_a (
    .rom_backdoor_clk(clk), .S_AXI_ROM_ARESETN(rst_n),
    .S_AXI_ROM_AWVALID(awvalid), .S_AXI_ROM_AWREADY(awready_a), .S_AXI_ROM_AWADDR(awaddr),
    .S_AXI_ROM_WVALID(wvalid), .S_AXI_ROM_WREADY(wready_a), .S_AXI_ROM_WDATA(wdata),
    .S_AXI_ROM_WSTRB(wstrb), .S_AXI_ROM_BVALID(bvalid_a), .S_AXI_ROM_BREADY(bready),
    .S_AXI_ROM_BRESP(bresp_a), .S_AXI_ROM_ARVALID(arvalid), .S_AXI_ROM_ARREADY(arready_a),
    .S_AXI_ROM_ARADDR(araddr), .S_AXI_ROM_RVALID(rvalid_a), .S_AXI_ROM_RREADY(rready),
    .S_AXI_ROM_RDATA(rdata_a), .S_AXI_ROM_RRESP(rresp_a), .rom_backdoor_en(en_a),
    .rom_backdoor_we(we_a), .rom_backdoor_addr(addr_a), .rom_backdoor_din(din_a),
    .rom_backdoor_dout(dout_a), .rom_backdoor_rst(rst_a)
`ifdef ROM_BACKDOOR_WR_LOCK_EN
    , .rom_wr_lock(wr_lock)
`endif
  );

  rom_backdoor_axil_bridge #(.RD_LATENCY(2), .ROM_BYTES(131072)) u_dut_b (
    .rom_backdoor_clk(clk), .S_AXI_ROM_ARESETN(rst_n),
    .S_AXI_ROM_AWVALID(awvalid), .S_AXI_ROM_AWREADY(awready_b), .S_AXI_ROM_AWADDR(awaddr),
    .S_AXI_ROM_WVALID(wvalid), .S_AXI_ROM_WREADY(wready_b), .S_AXI_ROM_WDATA(wdata),
    .S_AXI_ROM_WSTRB(wstrb), .S_AXI_ROM_BVALID(bvalid_b), .S_AXI_ROM_BREADY(bready),
    .S_AXI_ROM_BRESP(bresp_b), .S_AXI_ROM_ARVALID(arvalid), .S_AXI_ROM_ARREADY(arready_b),
    .S_AXI_ROM_ARADDR(araddr), .S_AXI_ROM_RVALID(rvalid_b), .S_AXI_ROM_RREADY(rready),
    .S_AXI_ROM_RDATA(rdata_b), .S_AXI_ROM_RRESP(rresp_b), .rom_backdoor_en(en_b),
    .rom_backdoor_we(we_b), .rom_backdoor_addr(addr_b), .rom_backdoor_din(din_b),
    .rom_backdoor_dout(dout_b), .rom_backdoor_rst(rst_b)
`ifdef ROM_BACKDOOR_WR_LOCK_EN
    , .rom_wr_lock(wr_lock)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rvalid_a) rv_cnt_a <= rv_cnt_a + 1;
    if (rvalid_b) rv_cnt_b <= rv_cnt_b + 1;
  end

  // BRAM models: dout valid 1 cycle (a) or 2 cycles (b) after en
  always @(posedge clk) begin
    if (en_a) begin
      en_cnt_a    <= en_cnt_a + 1;
      last_addr_a <= addr_a;
      last_we_a   <= we_a;
      for (int i = 0; i < 4; i++)
        if (we_a[i]) mem_a[addr_a[16:2]][i*8 +: 8] <= din_a[i*8 +: 8];
      dout_a <= mem_a[addr_a[16:2]];
    end
    if (en_b) begin
      en_cnt_b <= en_cnt_b + 1;
      for (int i = 0; i < 4; i++)
        if (we_b[i]) mem_b[addr_b[16:2]][i*8 +: 8] <= din_b[i*8 +: 8];
      pipe_b <= mem_b[addr_b[16:2]];
    end
    dout_b <= pipe_b;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] r1, output logic [1:0] r2, output int lat);
    int h;
    @(negedge clk);
    awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = s;
    for (int n = 0; n < 50 && !(awready_a && wready_a); n++) @(negedge clk);
    h = cyc;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    for (int n = 0; n < 50 && !bvalid_a; n++) @(negedge clk);
    lat = cyc - h;
    r1 = bresp_a;
    r2 = bvalid_b ? bresp_b : 2'b11;
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d1, output logic [31:0] d2,
                          output logic [1:0] r1, output logic [1:0] r2,
                          output int lat1, output int lat2, output logic stable);
    int h;
    @(negedge clk);
    arvalid = 1'b1; araddr = a;
    for (int n = 0; n < 50 && !arready_a; n++) @(negedge clk);
    h = cyc;
    @(negedge clk);
    arvalid = 1'b0;
    lat1 = -1; lat2 = -1;
    for (int n = 0; n < 50; n++) begin
      if (rvalid_a && lat1 < 0) lat1 = cyc - h;
      if (rvalid_b && lat2 < 0) lat2 = cyc - h;
      if (lat1 >= 0 && lat2 >= 0) break;
      @(negedge clk);
    end
    d1 = rdata_a; d2 = rdata_b; r1 = rresp_a; r2 = rresp_b;
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (rdata_a !== d1 || rdata_b !== d2 || rresp_a !== r1 || rresp_b !== r2 ||
          !rvalid_a || !rvalid_b) stable = 1'b0;
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  logic [1:0]  r1, r2;
  logic [31:0] d1, d2;
  int          lat, lat1, lat2, e0, e0b, h0, rv0, rv0b;
  logic        stable;

  initial begin
    rst_n = 1'b0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; wdata = '0; araddr = '0; wstrb = '0;
`ifdef ROM_BACKDOOR_WR_LOCK_EN
    wr_lock = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_awready", {awready_a, wready_a, arready_a, awready_b, wready_b, arready_b}, 0);
    chk("rst_valid", {bvalid_a, rvalid_a, bvalid_b, rvalid_b, en_a, en_b}, 0);
    chk("rst_payload", {bresp_a, rresp_a, we_a, addr_a}, 0);
    chk("rst_rdata", rdata_a | rdata_b | din_a, 0);
    chk("rst_out", {rst_a, rst_b}, 2'b11);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", {awready_a, wready_a, arready_a, rst_a}, 4'b1110);

    // write with AW three cycles ahead of W
    @(negedge clk);
    awvalid = 1'b1; awaddr = 32'h100;
    @(negedge clk);
    awvalid = 1'b0;
    chk("aw_held", {awready_a, wready_a, arready_a}, 3'b010);
    @(negedge clk);
    @(negedge clk);
    wvalid = 1'b1; wdata = 32'hDEADBEEF; wstrb = 4'hF; e0 = en_cnt_a; h0 = cyc;
    @(negedge clk);
    wvalid = 1'b0;
    chk("wr_en", {en_a, we_a, bvalid_a}, {1'b1, 4'hF, 1'b0});
    chk("wr_addr", addr_a, 32'h100);
    chk("wr_din", din_a, 32'hDEADBEEF);
    @(negedge clk);
    chk("wr_bvalid", {bvalid_a, bresp_a, en_a}, {1'b1, 2'b00, 1'b0});
    chk("wr_blat", cyc - h0, 2);
    chk("wr_en_once", en_cnt_a - e0, 1);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("wr_bdone", {bvalid_a, awready_a}, 2'b01);

    axi_read(32'h100, d1, d2, r1, r2, lat1, lat2, stable);
    chk("rd_data_l1", d1, 32'hDEADBEEF);
    chk("rd_data_l2", d2, 32'hDEADBEEF);
    chk("rd_resp", {r1, r2}, 0);
    chk("rd_lat_l1", lat1, 3);
    chk("rd_lat_l2", lat2, 4);
    chk("rd_stable", stable, 1);

    // out of range
    e0 = en_cnt_a; e0b = en_cnt_b;
    axi_write(32'h20000, 32'h0BADF00D, 4'hF, r1, r2, lat);
    chk("oor_bresp", {r1, r2}, 4'b1010);
    chk("oor_wlat", lat, 2);
    axi_read(32'h20000, d1, d2, r1, r2, lat1, lat2, stable);
    chk("oor_rdata", d1 | d2, 0);
    chk("oor_rresp", {r1, r2}, 4'b1010);
    chk("oor_rlat", {lat1[7:0], lat2[7:0]}, 16'h0304);
    chk("oor_no_en", {en_cnt_a - e0, en_cnt_b - e0b}, 0);

    // last word, low address bits ignored
    axi_write(32'h1FFFE, 32'h55AA55AA, 4'hF, r1, r2, lat);
    chk("top_bresp", r1, 0);
    chk("top_addr", last_addr_a, 32'h1FFFC);
    axi_read(32'h1FFFC, d1, d2, r1, r2, lat1, lat2, stable);
    chk("top_rdata", {d1 ^ d2, d1}, {32'h0, 32'h55AA55AA});

    // byte strobes, including an all-zero strobe
    axi_write(32'h104, 32'hAAAAAAAA, 4'hF, r1, r2, lat);
    axi_write(32'h104, 32'h11223344, 4'h3, r1, r2, lat);
    chk("strb_we", last_we_a, 4'h3);
    e0 = en_cnt_a;
    axi_write(32'h104, 32'hFFFFFFFF, 4'h0, r1, r2, lat);
    chk("strb0", {en_cnt_a - e0, 28'h0, last_we_a, r1}, {32'd1, 28'h0, 4'h0, 2'b00});
    axi_read(32'h104, d1, d2, r1, r2, lat1, lat2, stable);
    chk("strb_rdata", d1, 32'hAAAA3344);
    chk("strb_rdata_b", d2, 32'hAAAA3344);

    // AR/AW/W collision: write first
    @(negedge clk);
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    awaddr = 32'h200; araddr = 32'h200; wdata = 32'hCAFEF00D; wstrb = 4'hF;
    #1;
    chk("col_arready0", {arready_a, awready_a, wready_a}, 3'b011);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    chk("col_wr_acc", {en_a, arready_a}, 2'b10);
    @(negedge clk);
    chk("col_wr_resp", {bvalid_a, arready_a}, 2'b10);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("col_arready1", {bvalid_a, arready_a}, 2'b01);
    arvalid = 1'b0;
    axi_read(32'h200, d1, d2, r1, r2, lat1, lat2, stable);
    chk("col_rdata", {d1, d2}, {32'hCAFEF00D, 32'hCAFEF00D});

    // reset in RD_WAIT
    rv0 = rv_cnt_a; rv0b = rv_cnt_b;
    @(negedge clk);
    arvalid = 1'b1; araddr = 32'h100;
    @(negedge clk);
    arvalid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out", {en_a, rvalid_a, arready_a, rst_a, en_b, rvalid_b, rst_b}, 7'b0001001);
    repeat (6) @(negedge clk);
    chk("mid_rst_no_r", {rv_cnt_a - rv0, rv_cnt_b - rv0b}, 0);
    rst_n = 1'b1;
    axi_read(32'h100, d1, d2, r1, r2, lat1, lat2, stable);
    chk("post_rst_rd", {d1, d2}, {32'hDEADBEEF, 32'hDEADBEEF});
    chk("post_rst_lat", {lat1[7:0], lat2[7:0], r1, r2}, {16'h0304, 4'h0});

`ifdef ROM_BACKDOOR_WR_LOCK_EN
    wr_lock = 1'b1;
    e0 = en_cnt_a;
    axi_write(32'h100, 32'h12345678, 4'hF, r1, r2, lat);
    chk("lock_bresp", {r1, r2}, 4'b1010);
    chk("lock_no_en", en_cnt_a - e0, 0);
    axi_read(32'h100, d1, d2, r1, r2, lat1, lat2, stable);
    chk("lock_rd", {d1, 30'h0, r1}, {32'hDEADBEEF, 32'h0});
    wr_lock = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
